bcd2bin_seq: RTL
================

# bcd2bin_seq

Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from any digit ≥ 8. It is the inverse of the scoreboard's binary-to-BCD path. Score and setting values entered or stored as BCD digits are converted back to binary for game-logic arithmetic. One conversion is in flight at a time, with a valid/ready handshake on both sides.

## Interface
- NDIGITS, 3, number of BCD digits on the input (digit 0 = ones in bits [3:0])
- BIN_W, 10, binary result width; must satisfy 2^BIN_W ≥ 10^NDIGITS
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  bcd_in holds a value to convert
- in_ready  out  1  converter can accept; high only in IDLE
- bcd_in  in  4*NDIGITS  packed BCD, most significant digit in the top nibble
- out_valid  out  1  bin_out/err hold a result
- out_ready  in  1  consumer takes the result
- bin_out  out  BIN_W  binary value; held stable while out_valid
- err  out  1  some input digit was > 9; qualified by out_valid

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**: in_ready=1.
  - On in_valid, check every nibble of bcd_in.
  - If any nibble > 9: latch err=1 and bin_out=0, then go to DONE.
  - Otherwise: load the working BCD register with bcd_in, clear the binary shift register and iteration counter, set err=0, then go to SHIFT.
- **SHIFT**: each cycle performs one iteration.
  - Shift the concatenation {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
  - Then, in every post-shift digit of bcd_reg, replace a value ≥ 8 with value − 3.
  - The counter runs 0..BIN_W−1. The edge that performs iteration BIN_W−1 moves to DONE.
  - bin_out is driven from bin_reg, which holds the final value on entry to DONE.
- **DONE**: out_valid=1, bin_out and err held. On out_ready, go to IDLE.
- A new input is never accepted in the same cycle as the output handshake; in_ready is low in DONE.
- Arithmetic: digit correction is 4-bit unsigned. All digits are corrected in parallel within one cycle. Upper bits of bin_reg shift in zeros only via bcd_reg.
- in_valid while in_ready=0 is ignored; the upstream block must hold its data.
- out_ready while out_valid=0 has no effect.
- bcd_in is sampled only on the accepting edge. Changes afterwards have no effect.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, counter=0.
- Valid input accepted at edge k: out_valid rises after edge k+BIN_W (latency BIN_W cycles; 10 by default).
- Invalid input accepted at edge k: out_valid=1, err=1 after edge k+1.
- Output handshake at edge m: in_ready=1 after edge m. Minimum period is BIN_W+2 cycles per conversion.
- rst asserted in any state, including mid-SHIFT or DONE with a pending result: the next edge returns all outputs to reset values and discards the conversion. No partial result is emitted.
- rst dominates in_valid and out_ready on the same edge.

## Structure
- Package bcd_pkg holds:
  - the state typedef (IDLE/SHIFT/DONE)
  - localparams DIGIT_W=4, DIGIT_MAX=9, CORR_THRESH=8, CORR_SUB=3
  - the function computing the counter width from BIN_W
- Sub-module bcd_sub3_digit: 4-bit combinational correction (≥8 → −3, else pass). Instantiate it NDIGITS times via generate. It is the inverse counterpart of the scoreboard's add-3 digit map.
- Top: FSM, iteration counter, bcd_reg, bin_reg, err register.

## Test plan
- bcd_in=0x999 with out_ready held high → out_valid exactly 10 cycles after accept, bin_out=999 (10'h3E7), err=0.
- bcd_in=0x000, then 0x128, back-to-back → bin_out=0, then 128 (10'h080). in_ready is low from accept until the DONE handshake.
- bcd_in=0x1A5 → out_valid after 1 cycle, err=1, bin_out=0. The next valid input 0x042 gives bin_out=42, err=0.
- Backpressure: 0x365 converted with out_ready low for 20 cycles → out_valid and bin_out=365 stay stable. in_valid pulses during this time are not accepted. Output clears one cycle after out_ready rises.
- rst asserted in the 5th SHIFT cycle of 0x777 → next cycle shows IDLE reset values and no out_valid. A fresh 0x777 then yields 777.
- Exhaustive sweep 0x000..0x999 (valid digits only) → bin_out equals the decimal value for every input.

Source files
------------

// File: rtl/bcd2bin_seq_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_t      : converter FSM states (IDLE, SHIFT, DONE)
//   DIGIT_W      : bits per BCD digit
//   DIGIT_MAX    : largest legal BCD digit value
//   CORR_THRESH  : post-shift digit value at or above which correction applies
//   CORR_SUB     : amount subtracted from a digit that needs correction
//   cnt_width()  : width of an iteration counter that must reach bin_w-1
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;

    // Smallest width (at least 1) whose range covers 0..bin_w-1.
    function automatic int cnt_width(input int bin_w);
        int w;
        w = 1;
        while ((1 << w) < bin_w) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// ----------------------------------------------------------------------------
// bcd2bin_seq_if
// Handshake bundle between a BCD producer/consumer and the converter.
//   in_valid  : producer -> converter, bcd_in holds a value to convert
//   in_ready  : converter -> producer, converter can accept
//   bcd_in    : packed BCD, digit 0 (ones) in bits [3:0]
//   out_valid : converter -> consumer, bin_out/err hold a result
//   out_ready : consumer -> converter, result taken
//   bin_out   : binary result
//   err       : some input digit was > 9 (qualified by out_valid)
// The master modport is the producer/consumer side, slave is the converter.
// ----------------------------------------------------------------------------
interface bcd2bin_seq_if
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DIGIT_W*NDIGITS-1:0]   bcd_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [BIN_W-1:0]             bin_out;
    logic                         err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );

endinterface

// File: rtl/bcd2bin_seq_sub3.sv
// ----------------------------------------------------------------------------
// bcd_sub3_digit
// Combinational correction of one BCD digit after a right shift: a value of
// 8 or more has 3 subtracted, anything else passes through. Inverse of the
// add-3 digit map used by binary-to-BCD conversion.
//   i_digit : post-shift digit
//   o_digit : corrected digit
// ----------------------------------------------------------------------------
module bcd_sub3_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= CORR_THRESH) ? (i_digit - CORR_SUB) : i_digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// ----------------------------------------------------------------------------
// bcd2bin_seq
// Sequential BCD-to-binary converter (reverse double dabble). Each SHIFT cycle
// shifts {bcd, bin} right by one and corrects every BCD digit in parallel;
// after BIN_W iterations bin holds the binary value. One conversion in flight.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of bcd2bin_seq_if (in_valid/in_ready/bcd_in on the
//          input, out_valid/out_ready/bin_out/err on the output)
// ----------------------------------------------------------------------------
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
)(
    input  logic          clk,
    input  logic          rst,
    bcd2bin_seq_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * NDIGITS;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [BCD_W-1:0]   w_bcd_shift;
    logic [BCD_W-1:0]   w_bcd_corr;
    logic [BIN_W-1:0]   w_bin_shift;
    logic               w_in_bad;

    // The LSB of the BCD register falls into the MSB of the binary register.
    assign w_bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};
    assign w_bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};

    for (genvar g = 0; g < NDIGITS; g++) begin : g_corr
        bcd_sub3_digit u_sub3 (
            .i_digit (w_bcd_shift[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_bcd_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Flag an input word containing any nibble above 9.
    always_comb begin
        w_in_bad = 1'b0;
        for (int d = 0; d < NDIGITS; d++) begin
            w_in_bad = w_in_bad | (bus.bcd_in[d*DIGIT_W +: DIGIT_W] > DIGIT_MAX);
        end
    end

    // Converter FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bcd       <= '0;
            r_bin       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_bin      <= '0;
                        if (w_in_bad) begin
                            // Bad digit: latch the error result, skip conversion.
                            r_err   <= 1'b1;
                            r_bcd   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_bcd   <= bus.bcd_in;
                            r_state <= SHIFT;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_corr;
                    r_bin <= w_bin_shift;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    // The error path enters DONE with out_valid still low, so
                    // its result is published one edge after the accept.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_bcd       <= '0;
                    r_bin       <= '0;
                    r_cnt       <= '0;
                    r_err       <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bin_out   = r_bin;
    assign bus.err       = r_err;

endmodule
